// File: rtl/pixel_dispatcher.sv
// Raster-order frame scheduler: hands pixel coordinates to idle iteration cores
// round-robin, tracks in-flight jobs and pulses frame_done when a full frame drains.
module pixel_dispatcher #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int NCORES = 4,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NCORES-1:0] core_done,
  output logic [NCORES-1:0] core_start,
  output logic [XW-1:0]     job_x,
  output logic [YW-1:0]     job_y,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    DRAIN_ABORT,
    DONE
  } state_t;

  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

  state_t            state, state_nxt;
  logic [XW-1:0]     x, x_nxt;
  logic [YW-1:0]     y, y_nxt;
  logic [PW-1:0]     rr_ptr, rr_nxt;
  logic [NCORES-1:0] core_busy;
  logic [NCORES-1:0] grant;
  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  logic              issue;

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NCORES) s = s - NCORES;
    return PW'(s);
  endfunction

  // Round-robin search over the registered busy map, starting at rr_ptr
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (!grant_vld && !core_busy[rr_index(rr_ptr, k)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_index(rr_ptr, k);
      end
    end
    grant = '0;
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    rr_nxt    = rr_ptr;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DISPATCH;
          x_nxt     = '0;
          y_nxt     = '0;
          rr_nxt    = '0;
        end
      end
      DISPATCH: begin
        if (abort) begin
          state_nxt = DRAIN_ABORT;
        end else if (grant_vld) begin
          issue  = 1'b1;
          rr_nxt = rr_index(grant_idx, 1);
          if (x == XMAX && y == YMAX) begin
            state_nxt = DRAIN;
            x_nxt     = '0;
            y_nxt     = '0;
          end else if (x == XMAX) begin
            x_nxt = '0;
            y_nxt = y + 1'b1;
          end else begin
            x_nxt = x + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (abort)               state_nxt = DRAIN_ABORT;
        else if (core_busy == '0) state_nxt = DONE;
      end
      DRAIN_ABORT: begin
        if (core_busy == '0) begin
          state_nxt = IDLE;
          x_nxt     = '0;
          y_nxt     = '0;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A grant only ever targets a clear bit, so set and clear never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      rr_ptr     <= '0;
      core_busy  <= '0;
      core_start <= '0;
      job_x      <= '0;
      job_y      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      x          <= x_nxt;
      y          <= y_nxt;
      rr_ptr     <= rr_nxt;
      core_busy  <= (core_busy & ~core_done) | (issue ? grant : '0);
      core_start <= issue ? grant : '0;
      if (issue) begin
        job_x <= x;
        job_y <= y;
      end
      busy       <= (state_nxt != IDLE);
      frame_done <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Randomized bench for pixel_dispatcher: a job-level model (pixel counter, busy set,
// round-robin pointer) predicts every registered output cycle by cycle.
module tb_pixel_dispatcher;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = 4;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  core_done = '0;
  logic [N-1:0]  core_start;
  logic [XW-1:0] job_x;
  logic [YW-1:0] job_y;
  logic          busy;
  logic          frame_done;

  pixel_dispatcher #(.WIDTH(W), .HEIGHT(H), .NCORES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .core_done(core_done), .core_start(core_start), .job_x(job_x),
    .job_y(job_y), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Job-level model: 0 idle, 1 dispatching, 2 draining, 3 aborting, 4 done
  int           mphase = 0;
  int           issued = 0;
  logic [N-1:0] mbusy = '0;
  int           mrr = 0;
  int           cnt[N];
  bit           hold = 0;
  bit           spur_en = 0;
  bit           abort_en = 0;
  int           fd_seen = 0;
  int           starts_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mphase = 0; issued = 0; mbusy = '0; mrr = 0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
  endtask

  task automatic tick(input logic st, input logic ab, input logic [N-1:0] xdone);
    logic [N-1:0] d;
    logic [N-1:0] exp_cs;
    int exp_x, exp_y, nph, found, idx;
    @(negedge clk);
    d = xdone;
    for (int i = 0; i < N; i++) begin
      if (xdone[i]) cnt[i] = 0;
      else if (cnt[i] == 1) begin d[i] = 1'b1; cnt[i] = 0; end
      else if (cnt[i] > 1) cnt[i]--;
      else if (spur_en && cnt[i] == 0 && !mbusy[i] && $urandom_range(0, 7) == 0) d[i] = 1'b1;
    end
    start = st; abort = ab; core_done = d;
    exp_cs = '0; exp_x = 0; exp_y = 0; nph = mphase;
    case (mphase)
      0: if (st) begin nph = 1; issued = 0; mrr = 0; end
      1: if (ab) nph = 3;
         else begin
           found = -1;
           for (int k = 0; k < N; k++) begin
             idx = (mrr + k) % N;
             if (found < 0 && !mbusy[idx]) found = idx;
           end
           if (found >= 0) begin
             exp_cs[found] = 1'b1;
             exp_x = issued % W;
             exp_y = issued / W;
             issued++;
             mrr = (found + 1) % N;
             if (issued == W * H) nph = 2;
           end
         end
      2: if (ab) nph = 3; else if (mbusy == '0) nph = 4;
      3: if (mbusy == '0) nph = 0;
      default: nph = 0;
    endcase
    mbusy = (mbusy & ~d) | exp_cs;
    mphase = nph;
    @(posedge clk);
    #1;
    chk("core_start", 32'(core_start), 32'(exp_cs));
    chk("busy", 32'(busy), 32'(mphase != 0));
    chk("frame_done", 32'(frame_done), 32'(mphase == 4));
    if (exp_cs != '0) begin
      chk("job_x", 32'(job_x), 32'(exp_x));
      chk("job_y", 32'(job_y), 32'(exp_y));
    end
    if (frame_done) fd_seen++;
    if (core_start != '0) starts_seen++;
    for (int i = 0; i < N; i++)
      if (core_start[i]) cnt[i] = hold ? -1 : int'($urandom_range(1, 4));
  endtask

  task automatic run_until_idle(input int budget);
    int c;
    c = 0;
    while (mphase != 0 && c < budget) begin
      tick(spur_en && $urandom_range(0, 9) == 0,
           abort_en && $urandom_range(0, 29) == 0, '0);
      c++;
    end
    if (mphase != 0) chk("idle_timeout", 32'(mphase), 32'd0);
  endtask

  initial begin
    int fd0, s0, c;
    model_reset();
    #3;
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_job_xy", {16'(job_x), 16'(job_y)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain frame with echoing cores
    s0 = starts_seen;
    tick(1'b1, 1'b0, '0);
    run_until_idle(200);
    chk("frame1_starts", 32'(starts_seen - s0), 32'(W * H));
    chk("frame1_done", 32'(fd_seen), 32'd1);
    chk("frame1_busy", 32'(busy), 32'd0);

    // Spurious dones and stray start pulses mid-frame
    spur_en = 1;
    tick(1'b1, 1'b0, '0);
    run_until_idle(300);
    chk("frame2_done", 32'(fd_seen), 32'd2);
    spur_en = 0;

    // All cores held busy, then selective release
    hold = 1;
    s0 = starts_seen;
    tick(1'b1, 1'b0, '0);
    repeat (8) tick(1'b0, 1'b0, '0);
    chk("hold_starts", 32'(starts_seen - s0), 32'(N));
    tick(1'b0, 1'b0, 4'b0100);
    tick(1'b0, 1'b0, '0);
    chk("hold_regrant", 32'(core_start), 32'b0100);
    tick(1'b0, 1'b0, 4'b1001);
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    hold = 0;
    for (int i = 0; i < N; i++) if (cnt[i] == -1) cnt[i] = int'($urandom_range(1, 4));
    run_until_idle(300);
    chk("frame3_done", 32'(fd_seen), 32'd3);

    // Abort after five dispatches
    fd0 = fd_seen;
    tick(1'b1, 1'b0, '0);
    c = 0;
    while (issued < 5 && c < 50) begin tick(1'b0, 1'b0, '0); c++; end
    chk("abort_reach5", 32'(issued), 32'd5);
    tick(1'b0, 1'b1, '0);
    run_until_idle(200);
    chk("abort_no_done", 32'(fd_seen), 32'(fd0));
    chk("abort_busy", 32'(busy), 32'd0);
    tick(1'b1, 1'b0, '0);
    run_until_idle(300);
    chk("after_abort_done", 32'(fd_seen), 32'(fd0 + 1));

    // Reset mid-frame
    tick(1'b1, 1'b0, '0);
    repeat (3) tick(1'b0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_core_start", 32'(core_start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_job_xy", {16'(job_x), 16'(job_y)}, 32'd0);
    model_reset();
    start = 1'b0; abort = 1'b0; core_done = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("postrst_first", 32'(core_start), 32'b0001);
    run_until_idle(300);

    // Random mix of frames, aborts, spurious dones
    spur_en = 1;
    abort_en = 1;
    repeat (8) begin
      tick(1'b1, 1'b0, '0);
      run_until_idle(400);
      repeat ($urandom_range(0, 3)) tick(1'b0, 1'b0, '0);
    end
    chk("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
